// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Shares the register-bank write port between the writeback stage and debug
// register loads. Debug writes queue in a small FIFO and drain on cycles where
// writeback leaves the port free. A head entry that waits too long moves the
// FSM to STALL, which freezes the pipeline front-end until the FIFO is empty.
//
// Optional build macro: WB_ARB_COUNT_EN
//   Adds o_dbg_wr_cnt (debug pops, including discarded r0 writes) and
//   o_stall_cyc_cnt (cycles with o_pipe_stall high). Both are cleared by reset
//   and wrap modulo 2^32.
//
// Handshake: a debug write transfers on a cycle where i_dbg_valid and
// o_dbg_ready are both high. o_dbg_ready depends only on registered state and
// i_reset, never on i_dbg_valid. The requester holds reg/data stable while
// valid is high and ready is low.
module wb_write_arbiter #(
  parameter int NB_DATA      = 32,
  parameter int NB_REG       = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_REG-1:0]  i_write_reg,
  input  logic [NB_DATA-1:0] i_WB_data,
  input  logic               i_WB_write,
  input  logic               i_dbg_valid,
  output logic               o_dbg_ready,
  input  logic [NB_REG-1:0]  i_dbg_reg,
  input  logic [NB_DATA-1:0] i_dbg_data,
  output logic               o_pipe_stall,
  output logic               o_rf_write,
  output logic [NB_REG-1:0]  o_rf_reg,
  output logic [NB_DATA-1:0] o_rf_data,
`ifdef WB_ARB_COUNT_EN
  output logic [31:0]        o_dbg_wr_cnt,
  output logic [31:0]        o_stall_cyc_cnt,
`endif
  output logic               o_dbg_pending
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam int ENTRY_W = NB_REG + NB_DATA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Registered state
  state_t             r_state;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [AGE_W-1:0]   r_age;

  // Combinational helpers
  state_t             w_state_next;
  logic               w_full;
  logic               w_empty;
  logic               w_wb_grant;
  logic               w_port_free;
  logic               w_push;
  logic               w_pop;
  logic               w_last_entry;
  logic               w_age_at_limit;
  logic [NB_REG-1:0]  w_head_reg;
  logic [NB_DATA-1:0] w_head_data;

  assign w_full         = (r_count == CNT_W'(DEPTH));
  assign w_empty        = (r_count == '0);
  assign w_last_entry   = (r_count == CNT_W'(1));
  assign w_age_at_limit = (r_age == AGE_W'(STARVE_LIMIT - 1));
  assign w_wb_grant     = i_WB_write && (i_write_reg != '0);
  assign w_port_free    = !w_wb_grant;

  assign {w_head_reg, w_head_data} = r_mem[r_rd_ptr];

  // Ready comes from registered state; reset holds it low
  assign o_dbg_ready   = !i_reset && !w_full && (r_state != ST_STALL);
  assign o_pipe_stall  = !i_reset && (r_state == ST_STALL);
  assign o_dbg_pending = !i_reset && !w_empty;

  // A full FIFO never accepts, even when the head pops this same cycle
  assign w_push = i_dbg_valid && o_dbg_ready;
  assign w_pop  = !i_reset && w_port_free && !w_empty;

  // Write-port mux: writeback first, otherwise the FIFO head with zero latency
  always_comb begin
    o_rf_write = 1'b0;
    o_rf_reg   = i_write_reg;
    o_rf_data  = i_WB_data;
    if (i_reset) begin
      o_rf_write = 1'b0;
    end else if (w_wb_grant) begin
      o_rf_write = 1'b1;
    end else if (w_pop) begin
      // Debug loads to r0 are drained but never written
      o_rf_write = (w_head_reg != '0);
      o_rf_reg   = w_head_reg;
      o_rf_data  = w_head_data;
    end
  end

  // FIFO storage: entries are only written on an accepted push
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_dbg_reg, i_dbg_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head age: how long the current head has waited, saturating at the limit
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_age <= '0;
    end else if (w_pop || w_empty) begin
      r_age <= '0;
    end else if (r_age != AGE_W'(STARVE_LIMIT)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_push) begin
          w_state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_pop && w_last_entry && !w_push) begin
          w_state_next = ST_IDLE;
        end else if (w_age_at_limit && !w_pop) begin
          w_state_next = ST_STALL;
        end
      end
      ST_STALL: begin
        // No pushes are accepted here, so the last pop always empties the FIFO
        if (w_pop && w_last_entry) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

`ifdef WB_ARB_COUNT_EN
  logic [31:0] r_dbg_wr_cnt;
  logic [31:0] r_stall_cyc_cnt;

  // Activity counters for debug pops and stalled cycles
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dbg_wr_cnt    <= '0;
      r_stall_cyc_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_dbg_wr_cnt <= r_dbg_wr_cnt + 32'd1;
      end
      if (r_state == ST_STALL) begin
        r_stall_cyc_cnt <= r_stall_cyc_cnt + 32'd1;
      end
    end
  end

  assign o_dbg_wr_cnt    = r_dbg_wr_cnt;
  assign o_stall_cyc_cnt = r_stall_cyc_cnt;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_wb_write_arbiter;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int DEPTH   = 4;
  localparam int LIMIT   = 8;

  typedef struct {
    logic [NB_REG-1:0]  r;
    logic [NB_DATA-1:0] d;
  } entry_t;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NB_REG-1:0]  write_reg;
  logic [NB_DATA-1:0] wb_data;
  logic               wb_write;
  logic               dbg_valid;
  logic               dbg_ready;
  logic [NB_REG-1:0]  dbg_reg;
  logic [NB_DATA-1:0] dbg_data;
  logic               pipe_stall;
  logic               rf_write;
  logic [NB_REG-1:0]  rf_reg;
  logic [NB_DATA-1:0] rf_data;
  logic               dbg_pending;
`ifdef WB_ARB_COUNT_EN
  logic [31:0]        dbg_wr_cnt;
  logic [31:0]        stall_cyc_cnt;
`endif

  wb_write_arbiter #(
    .NB_DATA(NB_DATA), .NB_REG(NB_REG), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_write_reg(write_reg),
    .i_WB_data(wb_data),
    .i_WB_write(wb_write),
    .i_dbg_valid(dbg_valid),
    .o_dbg_ready(dbg_ready),
    .i_dbg_reg(dbg_reg),
    .i_dbg_data(dbg_data),
    .o_pipe_stall(pipe_stall),
    .o_rf_write(rf_write),
    .o_rf_reg(rf_reg),
    .o_rf_data(rf_data),
`ifdef WB_ARB_COUNT_EN
    .o_dbg_wr_cnt(dbg_wr_cnt),
    .o_stall_cyc_cnt(stall_cyc_cnt),
`endif
    .o_dbg_pending(dbg_pending)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  entry_t m_q[$];
  int     m_age   = 0;
  bit     m_stall = 1'b0;
  logic [31:0] m_pops  = '0;
  logic [31:0] m_stcyc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance the model
  task automatic step(input logic wbw, input logic [NB_REG-1:0] wbr,
                      input logic [NB_DATA-1:0] wbd, input logic dv,
                      input logic [NB_REG-1:0] dr, input logic [NB_DATA-1:0] dd,
                      input logic r);
    bit     port_free, pop, push, e_wr, e_ready, e_stall, e_pend, nxt_stall;
    entry_t head;
    @(negedge clk);
    rst = r; wb_write = wbw; write_reg = wbr; wb_data = wbd;
    dbg_valid = dv; dbg_reg = dr; dbg_data = dd;
    #1;
    port_free = !wbw || (wbr == '0);
    pop       = !r && port_free && (m_q.size() > 0);
    e_ready   = !r && (m_q.size() < DEPTH) && !m_stall;
    e_stall   = !r && m_stall;
    e_pend    = !r && (m_q.size() > 0);
    push      = dv && e_ready;
    chk("dbg_ready", 32'(dbg_ready), 32'(e_ready));
    chk("pipe_stall", 32'(pipe_stall), 32'(e_stall));
    chk("dbg_pending", 32'(dbg_pending), 32'(e_pend));
`ifdef WB_ARB_COUNT_EN
    chk("dbg_wr_cnt", dbg_wr_cnt, m_pops);
    chk("stall_cyc_cnt", stall_cyc_cnt, m_stcyc);
`endif
    if (r) begin
      e_wr = 1'b0;
    end else if (wbw && wbr != '0) begin
      e_wr = 1'b1;
      chk("rf_reg_wb", 32'(rf_reg), 32'(wbr));
      chk("rf_data_wb", rf_data, wbd);
    end else if (pop) begin
      head = m_q[0];
      e_wr = (head.r != '0);
      if (e_wr) begin
        chk("rf_reg_dbg", 32'(rf_reg), 32'(head.r));
        chk("rf_data_dbg", rf_data, head.d);
      end
    end else begin
      e_wr = 1'b0;
    end
    chk("rf_write", 32'(rf_write), 32'(e_wr));
    // Model update for the coming rising edge
    if (r) begin
      m_q.delete();
      m_age = 0; m_stall = 1'b0; m_pops = '0; m_stcyc = '0;
    end else begin
      if (m_stall) nxt_stall = !(pop && m_q.size() == 1);
      else         nxt_stall = (m_q.size() > 0) && (m_age == LIMIT - 1) && !pop;
      if (pop || m_q.size() == 0) m_age = 0;
      else if (m_age < LIMIT)     m_age++;
      if (pop) begin
        void'(m_q.pop_front());
        m_pops = m_pops + 32'd1;
      end
      if (push) m_q.push_back('{r: dr, d: dd});
      if (m_stall) m_stcyc = m_stcyc + 32'd1;
      m_stall = nxt_stall;
    end
  endtask

  task automatic idle_wb(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic busy_wb(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 5'd7, 32'hB0B0_0000 + i, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int first_stall;
    int bias;
    rst = 1'b1; wb_write = 1'b0; write_reg = '0; wb_data = '0;
    dbg_valid = 1'b0; dbg_reg = '0; dbg_data = '0;

    // Reset state
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    step(1'b1, 5'd5, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1);
    chk("reset_rf_write", 32'(rf_write), 32'd0);
    chk("reset_ready", 32'(dbg_ready), 32'd0);

    // WB write r5 with empty FIFO
    step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 1'b0);
    chk("wb_r5_write", 32'(rf_write), 32'd1);
    chk("wb_r5_ready", 32'(dbg_ready), 32'd1);

    // Push r3 under WB, drained on the next idle cycle
    step(1'b1, 5'd1, 32'hCAFE, 1'b1, 5'd3, 32'hAA, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("r3_drain_reg", 32'(rf_reg), 32'd3);
    idle_wb(1);
    chk("r3_pending_clear", 32'(dbg_pending), 32'd0);

    // Starvation: stall rises on the 8th edge after the capture edge
    step(1'b1, 5'd7, 32'h700, 1'b1, 5'd4, 32'h55, 1'b0);
    first_stall = -1;
    for (int i = 1; i <= 12; i++) begin
      busy_wb(1);
      if (pipe_stall && first_stall < 0) first_stall = i;
    end
    chk("stall_latency", 32'(first_stall), 32'd9);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("r4_drain_data", rf_data, 32'h55);
    idle_wb(1);
    chk("stall_drop", 32'(pipe_stall), 32'd0);

    // Fill the FIFO under WB, then offer a 5th entry including on a pop cycle
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 5'd7, 32'h1, 1'b1, 5'(10 + i), 32'h100 + i, 1'b0);
    step(1'b1, 5'd7, 32'h1, 1'b1, 5'd20, 32'hDEAD, 1'b0);
    chk("full_ready", 32'(dbg_ready), 32'd0);
    step(1'b0, '0, '0, 1'b1, 5'd20, 32'hDEAD, 1'b0);
    idle_wb(DEPTH + 1);

    // WB targeting r0 frees the port; debug r0 is drained silently
    step(1'b1, 5'd7, 32'h1, 1'b1, 5'd9, 32'h77, 1'b0);
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 1'b0);
    chk("r9_grant", 32'(rf_reg), 32'd9);
    step(1'b1, 5'd7, 32'h1, 1'b1, 5'd0, 32'h99, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("r0_discard", 32'(rf_write), 32'd0);
    idle_wb(1);

    // Reset while stalled with three entries queued
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd7, 32'h1, 1'b1, 5'(21 + i), 32'h300 + i, 1'b0);
    busy_wb(LIMIT + 2);
    chk("pre_reset_stall", 32'(pipe_stall), 32'd1);
    step(1'b1, 5'd7, 32'h1, 1'b0, '0, '0, 1'b1);
    step(1'b1, 5'd7, 32'h1, 1'b0, '0, '0, 1'b0);
    chk("post_reset_stall", 32'(pipe_stall), 32'd0);
    chk("post_reset_pending", 32'(dbg_pending), 32'd0);
    idle_wb(4);

    // Random traffic in segments of differing writeback load
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 2))
        0: bias = 30;
        1: bias = 70;
        default: bias = 97;
      endcase
      for (int i = 0; i < 40; i++) begin
        step(($urandom_range(0, 99) < bias),
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom,
             ($urandom_range(0, 99) < 40),
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom,
             ($urandom_range(0, 199) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Arbitrates the register-file write port between the pipeline writeback stage and the debug unit's register-load requests. Debug writes are buffered in a small FIFO and drained on cycles when writeback leaves the port free. If a debug write starves, the block stalls the pipeline front-end until the FIFO drains. The block sits between the writeback stage outputs and the register-bank write inputs.

Parameters:
NB_DATA, 32, register data width
NB_REG, 5, register address width
DEPTH, 4, debug FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, cycles a non-empty FIFO head may wait before a stall is requested (>=1)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_write_reg  in  NB_REG  WB destination register
i_WB_data  in  NB_DATA  WB data
i_WB_write  in  1  WB write request
i_dbg_valid  in  1  debug write request valid
o_dbg_ready  out  1  FIFO can accept a debug write
i_dbg_reg  in  NB_REG  debug destination register
i_dbg_data  in  NB_DATA  debug write data
o_pipe_stall  out  1  freeze pipeline front-end (IF..MEM)
o_rf_write  out  1  register-bank write enable
o_rf_reg  out  NB_REG  register-bank write address
o_rf_data  out  NB_DATA  register-bank write data
o_dbg_pending  out  1  FIFO non-empty

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high on i_reset; all state updates on the rising edge.
- Reset: FIFO flushed (count=0), age=0, FSM=IDLE, o_pipe_stall=0, o_dbg_pending=0, o_dbg_ready=0 while i_reset is high. o_rf_write is forced to 0 while i_reset is high. Reset mid-operation discards queued debug writes.
- Push: i_dbg_valid && o_dbg_ready captures {reg, data} at the tail. o_dbg_ready = !full && state!=STALL, computed from registered state only. When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- Port-free condition: i_WB_write==0 or i_write_reg==0.
- Pipeline write: if i_WB_write && i_write_reg!=0, drive o_rf_write=1 with the WB reg and data. Writeback always has priority. A WB write to r0 is suppressed (o_rf_write=0).
- Pop: if the port is free and the FIFO is non-empty, the head is popped in the same cycle, with zero latency through the combinational mux. The head drives o_rf_reg and o_rf_data, with o_rf_write = (head reg != 0). A debug write to r0 is popped and discarded.
- Simultaneous push and pop: allowed when not full; count is unchanged.
- Age counter: cleared on pop or when the FIFO is empty. Otherwise it increments and saturates at STARVE_LIMIT.
- FSM:
  - IDLE: FIFO empty. Goes to PEND on push.
  - PEND: goes to IDLE when a pop empties the FIFO with no push. Goes to STALL when age==STARVE_LIMIT-1 and no pop this cycle.
  - STALL: o_pipe_stall=1 (registered, Moore output). o_dbg_ready=0. Writeback still wins while a writeback instruction is in flight. Goes to IDLE on the cycle the last entry pops; o_pipe_stall drops the next cycle.
  - STALL duration is bounded by the WB drain cycles plus the FIFO count.
- o_dbg_pending = count!=0 (registered).

Optional Feature:
WB_ARB_COUNT_EN
- Defined: adds outputs o_dbg_wr_cnt[31:0] and o_stall_cyc_cnt[31:0].
  - o_dbg_wr_cnt counts debug pops, including discarded r0 writes.
  - o_stall_cyc_cnt counts cycles with o_pipe_stall=1.
  - Both are cleared by reset and wrap modulo 2^32.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then WB write r5=0x1234 with FIFO empty -> o_rf_write=1, o_rf_reg=5, o_rf_data=0x1234 in the same cycle; o_dbg_ready=1.
- Debug push r3=0xAA while i_WB_write=1, then WB idles next cycle -> r3=0xAA written that cycle; o_dbg_pending returns to 0 the following cycle.
- i_WB_write=1 continuously (reg 7), push r4=0x55, STARVE_LIMIT=8 -> o_pipe_stall rises 8 cycles after the push. Drop i_WB_write -> r4 written, o_pipe_stall falls the next cycle.
- Push 4 entries with WB busy (DEPTH=4) -> o_dbg_ready=0 after the 4th push. A 5th valid is held off, and no push occurs on a simultaneous full-pop cycle.
- WB write to r0 with a debug entry r9=0x77 queued -> r9 write granted that cycle. Debug entry for r0 -> popped with o_rf_write=0.
- Assert i_reset while in STALL with 3 queued entries -> next cycle o_pipe_stall=0, o_dbg_pending=0, and no stale entry is ever written.
